// File: rtl/mult_arbiter_if.sv
// Bundle of the per-thread request/result channels and the multiplier issue/return
// ports shared between the mult_arbiter and its environment.
interface mult_arbiter_if #(
    parameter int unsigned NUM_THREADS     = 2,
    parameter int unsigned NUM_THREADS_LOG = 1,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned FU_OP_BITS      = 4
);
    // per-thread request side
    logic [NUM_THREADS-1:0]                    req_valid_i;
    logic [NUM_THREADS-1:0]                    req_ready_o;
    logic [NUM_THREADS-1:0][FU_OP_BITS-1:0]    req_op_i;
    logic [NUM_THREADS-1:0][XLEN-1:0]          req_a_i;
    logic [NUM_THREADS-1:0][XLEN-1:0]          req_b_i;
    logic [NUM_THREADS-1:0][TRANS_ID_BITS-1:0] req_trans_id_i;
    logic [NUM_THREADS-1:0]                    flush_i;

    // multiplier issue port
    logic                       mult_valid_o;
    logic [FU_OP_BITS-1:0]      mult_op_o;
    logic [XLEN-1:0]            mult_a_o;
    logic [XLEN-1:0]            mult_b_o;
    logic [TRANS_ID_BITS-1:0]   mult_trans_id_o;
    logic [NUM_THREADS_LOG-1:0] mult_thread_id_o;

    // multiplier return port
    logic                       mult_valid_i;
    logic [XLEN-1:0]            mult_result_i;
    logic [TRANS_ID_BITS-1:0]   mult_trans_id_i;
    logic [NUM_THREADS_LOG-1:0] mult_thread_id_i;

    // per-thread result side
    logic [NUM_THREADS-1:0]                    res_valid_o;
    logic [NUM_THREADS-1:0]                    res_ready_i;
    logic [NUM_THREADS-1:0][XLEN-1:0]          res_data_o;
    logic [NUM_THREADS-1:0][TRANS_ID_BITS-1:0] res_trans_id_o;
    logic                                      lost_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_trans_id_i, flush_i,
        input  mult_valid_i, mult_result_i, mult_trans_id_i, mult_thread_id_i,
        input  res_ready_i,
        output req_ready_o,
        output mult_valid_o, mult_op_o, mult_a_o, mult_b_o, mult_trans_id_o, mult_thread_id_o,
        output res_valid_o, res_data_o, res_trans_id_o, lost_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_trans_id_i, flush_i,
        output mult_valid_i, mult_result_i, mult_trans_id_i, mult_thread_id_i,
        output res_ready_i,
        input  req_ready_o,
        input  mult_valid_o, mult_op_o, mult_a_o, mult_b_o, mult_trans_id_o, mult_thread_id_o,
        input  res_valid_o, res_data_o, res_trans_id_o, lost_err_o
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier between hardware threads,
// with a one-entry result slot per thread, flush handling and lost-result detection.
module mult_arbiter #(
    parameter int unsigned NUM_THREADS     = 2,
    parameter int unsigned NUM_THREADS_LOG = 1,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned FU_OP_BITS      = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mult_arbiter_if.slave   bus
);

    typedef logic [NUM_THREADS_LOG-1:0] thread_t;

    thread_t                                   rr_r;
    logic [NUM_THREADS-1:0]                    inflight_r;
    logic [NUM_THREADS-1:0]                    slot_valid_r;
    logic [NUM_THREADS-1:0]                    drop_r;
    logic [NUM_THREADS-1:0][XLEN-1:0]          slot_data_r;
    logic [NUM_THREADS-1:0][TRANS_ID_BITS-1:0] slot_tid_r;
    logic                                      lost_err_r;
    logic                                      rst_d_r;

    logic                   quiet_s;
    logic [NUM_THREADS-1:0] eligible_s;
    logic [NUM_THREADS-1:0] grant_vec_s;
    logic [NUM_THREADS-1:0] ret_hit_s;
    logic [NUM_THREADS-1:0] ret_load_s;
    logic                   grant_found_s;
    thread_t                grant_idx_s;

    // The reset cycle and the one after it are silent: no grants, no slot loads, outputs zero.
    assign quiet_s = rst_i | rst_d_r;

    // Thread may be granted only when idle, not flushing, and its slot can take the result.
    always_comb begin
        eligible_s = bus.req_valid_i & ~bus.flush_i & ~inflight_r
                   & (~slot_valid_r | bus.res_ready_i) & {NUM_THREADS{~quiet_s}};
    end

    // Round-robin search starting at rr_r; thread_t arithmetic wraps modulo NUM_THREADS.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (!grant_found_s && eligible_s[rr_r + thread_t'(i)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_r + thread_t'(i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_vec_s = grant_found_s ? ({{(NUM_THREADS-1){1'b0}}, 1'b1} << grant_idx_s)
                                    : {NUM_THREADS{1'b0}};
    end

    // Issue port follows the granted thread in the same cycle; all zero when idle.
    always_comb begin
        bus.req_ready_o = grant_vec_s;
        if (grant_found_s) begin
            bus.mult_valid_o     = 1'b1;
            bus.mult_op_o        = bus.req_op_i[grant_idx_s];
            bus.mult_a_o         = bus.req_a_i[grant_idx_s];
            bus.mult_b_o         = bus.req_b_i[grant_idx_s];
            bus.mult_trans_id_o  = bus.req_trans_id_i[grant_idx_s];
            bus.mult_thread_id_o = grant_idx_s;
        end else begin
            bus.mult_valid_o     = 1'b0;
            bus.mult_op_o        = '0;
            bus.mult_a_o         = '0;
            bus.mult_b_o         = '0;
            bus.mult_trans_id_o  = '0;
            bus.mult_thread_id_o = '0;
        end
    end

    // Decode which thread the multiplier is returning to and whether the slot accepts it.
    always_comb begin
        ret_hit_s  = {{(NUM_THREADS-1){1'b0}}, bus.mult_valid_i} << bus.mult_thread_id_i;
        ret_load_s = ret_hit_s & ~drop_r & ~bus.flush_i & {NUM_THREADS{~quiet_s}};
    end

    // Result slot and error flag outputs, forced to zero while quiet.
    always_comb begin
        bus.res_valid_o    = slot_valid_r & {NUM_THREADS{~quiet_s}};
        bus.res_data_o     = quiet_s ? '0 : slot_data_r;
        bus.res_trans_id_o = quiet_s ? '0 : slot_tid_r;
        bus.lost_err_o     = lost_err_r & ~quiet_s;
    end

    // Arbitration pointer, in-flight tracking, result slots, drop flags and lost-result error.
    always_ff @(posedge clk_i) begin
        rst_d_r <= rst_i;
        if (rst_i) begin
            rr_r         <= '0;
            inflight_r   <= '0;
            slot_valid_r <= '0;
            drop_r       <= '0;
            slot_data_r  <= '0;
            slot_tid_r   <= '0;
            lost_err_r   <= 1'b0;
        end else begin
            if (grant_found_s) begin
                rr_r <= grant_idx_s + thread_t'(1);
            end else begin
                rr_r <= rr_r;
            end
            inflight_r <= grant_vec_s;
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                // A fresh grant also retires a stale drop so its own return is kept.
                if (ret_hit_s[t] || grant_vec_s[t]) begin
                    drop_r[t] <= 1'b0;
                end else if (bus.flush_i[t] && inflight_r[t]) begin
                    drop_r[t] <= 1'b1;
                end else begin
                    drop_r[t] <= drop_r[t];
                end
                if (bus.flush_i[t]) begin
                    slot_valid_r[t] <= 1'b0;
                end else if (ret_load_s[t]) begin
                    slot_valid_r[t] <= 1'b1;
                    slot_data_r[t]  <= bus.mult_result_i;
                    slot_tid_r[t]   <= bus.mult_trans_id_i;
                end else if (slot_valid_r[t] && bus.res_ready_i[t]) begin
                    slot_valid_r[t] <= 1'b0;
                end else begin
                    slot_valid_r[t] <= slot_valid_r[t];
                end
            end
            if (|(inflight_r & ~ret_hit_s)) begin
                lost_err_r <= 1'b1;
            end else begin
                lost_err_r <= lost_err_r;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: one-cycle multiplier model, per-thread result
// scoreboard, and cycle-level checks of grants, flush, lost-result and reset behaviour.
module tb_mult_arbiter;
    localparam int unsigned N    = 2;
    localparam int unsigned LOG  = 1;
    localparam int unsigned XLEN = 64;
    localparam int unsigned TIDB = 3;
    localparam int unsigned OPB  = 4;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic suppress = 1'b0;
    logic inj = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb [N][$];

    always #5 clk = ~clk;

    mult_arbiter_if #(.NUM_THREADS(N), .NUM_THREADS_LOG(LOG), .XLEN(XLEN),
                      .TRANS_ID_BITS(TIDB), .FU_OP_BITS(OPB)) bus ();

    mult_arbiter #(.NUM_THREADS(N), .NUM_THREADS_LOG(LOG), .XLEN(XLEN),
                   .TRANS_ID_BITS(TIDB), .FU_OP_BITS(OPB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int t, input logic [63:0] d, input logic [2:0] id);
        exp_t e;
        e.data = d;
        e.tid  = id;
        sb[t].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_i    = '0;
        bus.req_op_i       = '0;
        bus.req_a_i        = '0;
        bus.req_b_i        = '0;
        bus.req_trans_id_i = '0;
        bus.flush_i        = '0;
    endtask

    // One-cycle multiplier model; can swallow a return or inject a spurious one.
    always @(posedge clk) begin
        if (inj) begin
            bus.mult_valid_i     <= 1'b1;
            bus.mult_result_i    <= 64'd99;
            bus.mult_trans_id_i  <= 3'd7;
            bus.mult_thread_id_i <= 1'b0;
        end else if (bus.mult_valid_o && !suppress) begin
            bus.mult_valid_i     <= 1'b1;
            bus.mult_result_i    <= bus.mult_a_o * bus.mult_b_o;
            bus.mult_trans_id_i  <= bus.mult_trans_id_o;
            bus.mult_thread_id_i <= bus.mult_thread_id_o;
        end else begin
            bus.mult_valid_i     <= 1'b0;
            bus.mult_result_i    <= 64'd0;
            bus.mult_trans_id_i  <= 3'd0;
            bus.mult_thread_id_i <= 1'b0;
        end
    end

    // Result consumer: every accepted result must match the scoreboard head.
    always @(negedge clk) begin
        for (int t = 0; t < N; t++) begin
            if (!rst && bus.res_valid_o[t] && bus.res_ready_i[t]) begin
                if (sb[t].size() == 0) begin
                    chk("res_unexpected", 64'(bus.res_valid_o[t]), 64'd0);
                end else begin
                    exp_t e;
                    e = sb[t].pop_front();
                    chk("res_data", bus.res_data_o[t], e.data);
                    chk("res_tid", 64'(bus.res_trans_id_o[t]), 64'(e.tid));
                end
            end
        end
    end

    initial begin
        logic [63:0] ea;
        logic [63:0] eb;
        logic [2:0]  et;
        int          g;

        // reset with requests pending: everything silent
        idle();
        bus.res_ready_i = 2'b00;
        bus.req_valid_i = 2'b11;
        bus.req_a_i[0]  = 64'd7;
        tick(); tick();
        chk("rst_mult_valid", 64'(bus.mult_valid_o), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("rst_lost_err", 64'(bus.lost_err_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("post_rst_mult_valid", 64'(bus.mult_valid_o), 64'd0);
        chk("post_rst_mult_a", bus.mult_a_o, 64'd0);
        tick();

        // single MUL 3*5, ID 2 on thread 0
        idle();
        bus.res_ready_i       = 2'b01;
        bus.req_valid_i       = 2'b01;
        bus.req_op_i[0]       = 4'd1;
        bus.req_a_i[0]        = 64'd3;
        bus.req_b_i[0]        = 64'd5;
        bus.req_trans_id_i[0] = 3'd2;
        push(0, 64'd15, 3'd2);
        #1;
        chk("issue_ready", 64'(bus.req_ready_o), 64'd1);
        chk("issue_valid", 64'(bus.mult_valid_o), 64'd1);
        chk("issue_op", 64'(bus.mult_op_o), 64'd1);
        chk("issue_a", bus.mult_a_o, 64'd3);
        chk("issue_b", bus.mult_b_o, 64'd5);
        chk("issue_tid", 64'(bus.mult_trans_id_o), 64'd2);
        chk("issue_thread", 64'(bus.mult_thread_id_o), 64'd0);
        tick();
        idle();
        #1;
        chk("return_cycle_res_valid", 64'(bus.res_valid_o), 64'd0);
        tick();
        chk("slot_res_valid", 64'(bus.res_valid_o), 64'd1);
        tick();

        // both threads continuously: pointer is at 1, so 1,0,1,0,...
        bus.res_ready_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            bus.req_valid_i       = 2'b11;
            bus.req_a_i[0]        = 64'(k + 2);
            bus.req_b_i[0]        = 64'(k + 7);
            bus.req_a_i[1]        = 64'(k + 20);
            bus.req_b_i[1]        = 64'(k + 3);
            bus.req_trans_id_i[0] = 3'(k);
            bus.req_trans_id_i[1] = 3'(k + 1);
            g  = (k % 2 == 0) ? 1 : 0;
            ea = (g == 1) ? 64'(k + 20) : 64'(k + 2);
            eb = (g == 1) ? 64'(k + 3)  : 64'(k + 7);
            et = (g == 1) ? 3'(k + 1)   : 3'(k);
            push(g, ea * eb, et);
            #1;
            chk("rr_valid", 64'(bus.mult_valid_o), 64'd1);
            chk("rr_thread", 64'(bus.mult_thread_id_o), 64'(g));
            chk("rr_a", bus.mult_a_o, ea);
            tick();
        end
        idle();
        tick(); tick(); tick();

        // back-pressure: full slot blocks thread 0 until res_ready_i[0] rises
        bus.res_ready_i       = 2'b00;
        bus.req_valid_i       = 2'b01;
        bus.req_a_i[0]        = 64'd4;
        bus.req_b_i[0]        = 64'd6;
        bus.req_trans_id_i[0] = 3'd1;
        push(0, 64'd24, 3'd1);
        #1;
        chk("bp_first_grant", 64'(bus.req_ready_o), 64'd1);
        tick();
        idle();
        tick();
        bus.req_valid_i       = 2'b01;
        bus.req_a_i[0]        = 64'd9;
        bus.req_b_i[0]        = 64'd9;
        bus.req_trans_id_i[0] = 3'd3;
        #1;
        chk("bp_blocked", 64'(bus.req_ready_o), 64'd0);
        chk("bp_slot_full", 64'(bus.res_valid_o), 64'd1);
        tick();
        chk("bp_still_blocked", 64'(bus.req_ready_o), 64'd0);
        bus.res_ready_i = 2'b01;
        push(0, 64'd81, 3'd3);
        #1;
        chk("bp_release_grant", 64'(bus.req_ready_o), 64'd1);
        tick();
        idle();
        tick(); tick(); tick();

        // flush of thread 1 in its return cycle drops the result
        bus.res_ready_i       = 2'b11;
        bus.req_valid_i       = 2'b10;
        bus.req_a_i[1]        = 64'd2;
        bus.req_b_i[1]        = 64'd2;
        bus.req_trans_id_i[1] = 3'd5;
        #1;
        chk("flush_issue", 64'(bus.req_ready_o), 64'd2);
        tick();
        bus.flush_i = 2'b10;
        #1;
        chk("flush_no_grant", 64'(bus.req_ready_o), 64'd0);
        chk("flush_idle_valid", 64'(bus.mult_valid_o), 64'd0);
        chk("flush_idle_a", bus.mult_a_o, 64'd0);
        tick();
        idle();
        #1;
        chk("flush_dropped_1", 64'(bus.res_valid_o[1]), 64'd0);
        tick();
        chk("flush_dropped_2", 64'(bus.res_valid_o[1]), 64'd0);
        chk("flush_no_lost", 64'(bus.lost_err_o), 64'd0);
        bus.req_valid_i       = 2'b10;
        bus.req_a_i[1]        = 64'd6;
        bus.req_b_i[1]        = 64'd7;
        bus.req_trans_id_i[1] = 3'd4;
        push(1, 64'd42, 3'd4);
        #1;
        chk("flush_regrant", 64'(bus.req_ready_o), 64'd2);
        tick();
        idle();
        tick(); tick(); tick();

        // swallowed return raises the sticky lost error
        bus.req_valid_i = 2'b01;
        bus.req_a_i[0]  = 64'd1;
        bus.req_b_i[0]  = 64'd1;
        suppress        = 1'b1;
        #1;
        chk("lost_issue", 64'(bus.req_ready_o), 64'd1);
        tick();
        idle();
        suppress = 1'b0;
        #1;
        chk("lost_not_yet", 64'(bus.lost_err_o), 64'd0);
        tick();
        chk("lost_set", 64'(bus.lost_err_o), 64'd1);
        tick();
        chk("lost_held", 64'(bus.lost_err_o), 64'd1);
        chk("lost_no_result", 64'(bus.res_valid_o), 64'd0);

        // reset the cycle after an issue; a spurious late return must be ignored
        bus.req_valid_i = 2'b01;
        bus.req_a_i[0]  = 64'd5;
        bus.req_b_i[0]  = 64'd5;
        #1;
        chk("mid_issue", 64'(bus.req_ready_o), 64'd1);
        chk("lost_before_rst", 64'(bus.lost_err_o), 64'd1);
        tick();
        rst             = 1'b1;
        inj             = 1'b1;
        bus.req_valid_i = 2'b11;
        #1;
        chk("mid_rst_mult_valid", 64'(bus.mult_valid_o), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("mid_rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        tick();
        rst = 1'b0;
        inj = 1'b0;
        #1;
        chk("after_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("after_rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("after_rst_lost", 64'(bus.lost_err_o), 64'd0);
        tick();
        bus.req_a_i[0]        = 64'd11;
        bus.req_b_i[0]        = 64'd2;
        bus.req_trans_id_i[0] = 3'd1;
        bus.req_a_i[1]        = 64'd12;
        bus.req_b_i[1]        = 64'd3;
        bus.req_trans_id_i[1] = 3'd2;
        push(0, 64'd22, 3'd1);
        #1;
        chk("first_grant_t0", 64'(bus.req_ready_o), 64'd1);
        chk("inj_ignored", 64'(bus.res_valid_o), 64'd0);
        tick();
        push(1, 64'd36, 3'd2);
        chk("second_grant_t1", 64'(bus.req_ready_o), 64'd2);
        tick();
        idle();
        tick(); tick(); tick();

        chk("sb0_drained", 64'(sb[0].size()), 64'd0);
        chk("sb1_drained", 64'(sb[1].size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
